// File: rtl/uart_rx_capture.sv
// 8N1 serial receiver feeding a small first-word-fall-through byte FIFO.
// Used at sim top level to capture console output cycle-accurately.
//
// state | meaning
// IDLE  | line idle, waiting for a falling edge on rx_s
// START | confirming start bit at half-bit point
// DATA  | sampling 8 data bits, LSB first
// STOP  | sampling stop bit; push on high, frame error on low
// BREAK | line held low after a framing error; wait for idle
module uart_rx_capture #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int BAUD        = 115200,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_rx,
  output logic [7:0]                   o_data,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic                         o_frame_err,
  output logic                         o_overflow,
  output logic [$clog2(FIFO_DEPTH):0]  o_level
);

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
  localparam int CW           = $clog2(CLKS_PER_BIT);
  localparam int AW           = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT / 2 - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] STOP  = 3'd3;
  localparam logic [2:0] BREAK = 3'd4;

  logic          rx_m;
  logic          rx_s;
  logic [2:0]    state;
  logic [CW-1:0] clk_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift_reg;
  logic          push;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW:0]   level;
  logic          full;
  logic          pop;
  logic          push_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= i_rx;
      rx_s <= rx_m;
    end
  end

  // Push decision is combinational so the byte lands in the FIFO on the stop-sample edge.
  assign push = (state == STOP) && (clk_cnt == CNT_LAST) && rx_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      clk_cnt     <= '0;
      bit_idx     <= '0;
      shift_reg   <= '0;
      o_frame_err <= 1'b0;
    end else begin
      o_frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            clk_cnt <= '0;
            state   <= START;
          end
        end
        START: begin
          if (clk_cnt == CNT_MID) begin
            clk_cnt <= '0;
            if (rx_s) begin
              state <= IDLE;
            end else begin
              bit_idx <= '0;
              state   <= DATA;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        DATA: begin
          if (clk_cnt == CNT_LAST) begin
            clk_cnt   <= '0;
            shift_reg <= {rx_s, shift_reg[7:1]};
            if (bit_idx == 3'd7) state <= STOP;
            else                 bit_idx <= bit_idx + 1'b1;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        STOP: begin
          if (clk_cnt == CNT_LAST) begin
            clk_cnt <= '0;
            if (rx_s) begin
              state <= IDLE;
            end else begin
              o_frame_err <= 1'b1;
              state       <= BREAK;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        BREAK: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign level   = wr_ptr - rd_ptr;
  assign full    = (level == (AW+1)'(FIFO_DEPTH));
  assign pop     = o_valid & i_ready;
  // When full, the slot being written is the head being popped this same cycle.
  assign push_ok = push & (~full | pop);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= shift_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (push && full && !pop) o_overflow <= 1'b1;
    end
  end

  assign o_valid = (level != '0);
  assign o_data  = o_valid ? mem[rd_ptr[AW-1:0]] : 8'h00;
  assign o_level = level;

endmodule
